id_stage: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline. Sits between the IF/ID latch and the EX stage.
- Drives the two read ports of the register file and applies EX/MEM forwarding on top of the register file's own same-cycle WB bypass.
- Detects load-use hazards and holds the ID/EX pipeline register, with bubble, stall and flush control.

---
 rtl/id_stage_pkg.sv | 57 +++++
 rtl/id_stage_imm.sv | 23 ++
 rtl/id_stage.sv | 179 +++++++++++++++++
 tb/tb_id_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV32I decode stage: opcodes, operation
// encodings, immediate formats and the funct3 to ALU-op map.
package id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [4:0]  ZERO_REG = 5'd0;
    localparam logic [31:0] ZERO     = 32'd0;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_LUI    = 5'd10,
        OP_AUIPC  = 5'd11,
        OP_JAL    = 5'd12,
        OP_JALR   = 5'd13,
        OP_BRANCH = 5'd14
    } op_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    // alt selects SUB/SRA; callers gate it so ADDI never becomes SUB
    function automatic op_e alu_op(input logic [2:0] funct3, input logic alt);
        op_e op;
        case (funct3)
            3'd0:    op = alt ? OP_SUB : OP_ADD;
            3'd1:    op = OP_SLL;
            3'd2:    op = OP_SLT;
            3'd3:    op = OP_SLTU;
            3'd4:    op = OP_XOR;
            3'd5:    op = alt ? OP_SRA : OP_SRL;
            3'd6:    op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_imm.sv
// Immediate generator: builds the sign-extended immediate for the decoded
// instruction format.
module imm_gen
    import id_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = ZERO;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = ZERO;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file read, EX/MEM operand forwarding,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_pc,
    input  logic [31:0]     if_inst,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            rf_re1,
    output logic [4:0]      rf_raddr1,
    input  logic [XLEN-1:0] rf_rdata1,
    output logic            rf_re2,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            ex_wreg,
    input  logic [4:0]      ex_waddr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            ex_is_load,
    input  logic            mem_wreg,
    input  logic [4:0]      mem_waddr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            stall_req,
    output logic            id_valid,
    output logic [31:0]     id_pc,
    output logic [OP_W-1:0] id_op,
    output logic [2:0]      id_funct3,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [31:0]     id_imm,
    output logic [4:0]      id_rd,
    output logic            id_wreg,
    output logic            id_is_load,
    output logic            id_is_store,
    output logic            id_is_branch,
    output logic            id_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    fmt_e            fmt;
    op_e             op;
    logic            use1, use2, is_load, is_store, is_branch, illegal;
    logic            wreg, hazard;
    logic [31:0]     imm;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode    = if_inst[6:0];
    assign funct3    = if_inst[14:12];
    assign rd        = if_inst[11:7];
    assign rf_raddr1 = if_inst[19:15];
    assign rf_raddr2 = if_inst[24:20];

    always_comb begin
        fmt       = FMT_NONE;
        op        = OP_ADD;
        use1      = 1'b0;
        use2      = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                fmt  = FMT_R;
                use1 = 1'b1;
                use2 = 1'b1;
                op   = alu_op(funct3, if_inst[30]);
            end
            OPC_OP_IMM: begin
                fmt  = FMT_I;
                use1 = 1'b1;
                op   = alu_op(funct3, if_inst[30] && (funct3 == 3'd5));
            end
            OPC_LOAD: begin
                fmt     = FMT_I;
                use1    = 1'b1;
                is_load = 1'b1;
            end
            OPC_STORE: begin
                fmt      = FMT_S;
                use1     = 1'b1;
                use2     = 1'b1;
                is_store = 1'b1;
            end
            OPC_BRANCH: begin
                fmt       = FMT_B;
                use1      = 1'b1;
                use2      = 1'b1;
                is_branch = 1'b1;
                op        = OP_BRANCH;
            end
            OPC_JALR: begin
                fmt       = FMT_I;
                use1      = 1'b1;
                is_branch = 1'b1;
                op        = OP_JALR;
            end
            OPC_JAL: begin
                fmt       = FMT_J;
                is_branch = 1'b1;
                op        = OP_JAL;
            end
            OPC_LUI: begin
                fmt = FMT_U;
                op  = OP_LUI;
            end
            OPC_AUIPC: begin
                fmt = FMT_U;
                op  = OP_AUIPC;
            end
            default: illegal = 1'b1;
        endcase
    end

    imm_gen u_imm_gen (
        .inst (if_inst),
        .fmt  (fmt),
        .imm  (imm)
    );

    assign rf_re1 = if_valid & use1;
    assign rf_re2 = if_valid & use2;
    assign wreg   = ~illegal & (fmt != FMT_S) & (fmt != FMT_B) & (rd != ZERO_REG);

    // EX beats MEM; WB bypass already lives inside the register file
    assign rs1_val = (!rf_re1 || rf_raddr1 == ZERO_REG)      ? '0 :
                     (ex_wreg && ex_waddr == rf_raddr1)      ? ex_wdata :
                     (mem_wreg && mem_waddr == rf_raddr1)    ? mem_wdata : rf_rdata1;
    assign rs2_val = (!rf_re2 || rf_raddr2 == ZERO_REG)      ? '0 :
                     (ex_wreg && ex_waddr == rf_raddr2)      ? ex_wdata :
                     (mem_wreg && mem_waddr == rf_raddr2)    ? mem_wdata : rf_rdata2;

    assign hazard = if_valid & ex_is_load & ex_wreg & (ex_waddr != ZERO_REG) &
                    ((rf_re1 & (ex_waddr == rf_raddr1)) | (rf_re2 & (ex_waddr == rf_raddr2)));

    assign stall_req = rst & ~flush & (ex_stall | hazard);

    // Reset, flush and a load-use bubble all leave an empty, zeroed ID/EX slot
    always_ff @(posedge clk) begin
        if (!rst || flush || (!ex_stall && hazard)) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_op        <= '0;
            id_funct3    <= '0;
            id_rs1_val   <= '0;
            id_rs2_val   <= '0;
            id_imm       <= '0;
            id_rd        <= '0;
            id_wreg      <= 1'b0;
            id_is_load   <= 1'b0;
            id_is_store  <= 1'b0;
            id_is_branch <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (!ex_stall) begin
            id_valid     <= if_valid;
            id_pc        <= if_pc;
            id_op        <= OP_W'(op);
            id_funct3    <= funct3;
            id_rs1_val   <= rs1_val;
            id_rs2_val   <= rs2_val;
            id_imm       <= imm;
            id_rd        <= rd;
            id_wreg      <= wreg;
            id_is_load   <= is_load;
            id_is_store  <= is_store;
            id_is_branch <= is_branch;
            id_illegal   <= illegal;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed pipeline scenarios plus random traffic, checked
// by a scoreboard fed from a behavioural decode/forwarding model.
module tb_id_stage;
    import id_stage_pkg::*;

    bit          clk = 1'b0;
    logic        rst, if_valid, ex_stall, flush;
    logic [31:0] if_pc, if_inst;
    logic        rf_re1, rf_re2;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_wreg, ex_is_load, mem_wreg;
    logic [4:0]  ex_waddr, mem_waddr;
    logic [31:0] ex_wdata, mem_wdata;
    logic        stall_req, id_valid, id_wreg, id_is_load, id_is_store, id_is_branch, id_illegal;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_op, id_rd;
    logic [2:0]  id_funct3;

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .ex_stall(ex_stall), .flush(flush),
        .rf_re1(rf_re1), .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
        .rf_re2(rf_re2), .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_req(stall_req), .id_valid(id_valid), .id_pc(id_pc), .id_op(id_op),
        .id_funct3(id_funct3), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_rd(id_rd), .id_wreg(id_wreg), .id_is_load(id_is_load),
        .id_is_store(id_is_store), .id_is_branch(id_is_branch), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hold;
        logic        chk;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wreg, ld, st, br, ill;
    } exp_t;

    localparam op_e ALU_TBL [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};

    exp_t q[$];
    exp_t last_e = '0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic stall_prev = 1'b0;
    logic stall_seen;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] fwd_m(logic en, logic [4:0] a, logic [31:0] rfd);
        if (!en || a == 5'd0) return 32'd0;
        if (ex_wreg && ex_waddr == a) return ex_wdata;
        if (mem_wreg && mem_waddr == a) return mem_wdata;
        return rfd;
    endfunction

    // Reference: what the ID/EX register should hold after the next edge
    function automatic void model(output exp_t e, output logic hz, output logic u1, output logic u2);
        logic [31:0] i;
        logic [2:0]  f3;
        byte         fmt;
        op_e         op;
        logic        ld, st, br, ill;
        logic [31:0] imm;
        i = if_inst; f3 = i[14:12];
        fmt = "-"; op = OP_ADD; ld = 0; st = 0; br = 0; ill = 0;
        case (i[6:0])
            OPC_OP: begin
                fmt = "R"; op = ALU_TBL[f3];
                if (i[30] && f3 == 3'd0) op = OP_SUB;
                if (i[30] && f3 == 3'd5) op = OP_SRA;
            end
            OPC_OP_IMM: begin
                fmt = "I"; op = ALU_TBL[f3];
                if (i[30] && f3 == 3'd5) op = OP_SRA;
            end
            OPC_LOAD:   begin fmt = "I"; ld = 1; end
            OPC_STORE:  begin fmt = "S"; st = 1; end
            OPC_BRANCH: begin fmt = "B"; br = 1; op = OP_BRANCH; end
            OPC_JALR:   begin fmt = "I"; br = 1; op = OP_JALR; end
            OPC_JAL:    begin fmt = "J"; br = 1; op = OP_JAL; end
            OPC_LUI:    begin fmt = "U"; op = OP_LUI; end
            OPC_AUIPC:  begin fmt = "U"; op = OP_AUIPC; end
            default:    ill = 1;
        endcase
        case (fmt)
            "I":     imm = 32'($signed(i[31:20]));
            "S":     imm = 32'($signed({i[31:25], i[11:7]}));
            "B":     imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            "U":     imm = i & 32'hFFFF_F000;
            "J":     imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: imm = 32'd0;
        endcase
        u1 = if_valid && (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
        u2 = if_valid && (fmt == "R" || fmt == "S" || fmt == "B");
        hz = if_valid && ex_is_load && ex_wreg && ex_waddr != 5'd0 &&
             ((u1 && i[19:15] == ex_waddr) || (u2 && i[24:20] == ex_waddr));
        e = '0;
        if (!rst || flush || (!ex_stall && hz)) begin
            e.chk = 1;
        end else if (ex_stall) begin
            e.hold = 1;
        end else begin
            e.chk = if_valid; e.valid = if_valid; e.pc = if_pc; e.op = op; e.f3 = f3;
            e.rs1 = fwd_m(u1, i[19:15], rf_rdata1);
            e.rs2 = fwd_m(u2, i[24:20], rf_rdata2);
            e.imm = imm; e.rd = i[11:7];
            e.wreg = !ill && fmt != "S" && fmt != "B" && i[11:7] != 5'd0;
            e.ld = ld; e.st = st; e.br = br; e.ill = ill;
        end
    endfunction

    task automatic cycle();
        exp_t e;
        logic hz, u1, u2, exp_stall;
        model(e, hz, u1, u2);
        exp_stall = rst && !flush && (ex_stall || hz);
        q.push_back(e);
        #1;
        stall_seen = stall_req;
        check("stall_req", 32'(stall_req), 32'(exp_stall));
        check("rf_re1", 32'(rf_re1), 32'(u1));
        check("rf_re2", 32'(rf_re2), 32'(u2));
        check("rf_raddr1", 32'(rf_raddr1), 32'(if_inst[19:15]));
        check("rf_raddr2", 32'(rf_raddr2), 32'(if_inst[24:20]));
        @(posedge clk);
        #1;
        stall_prev = exp_stall;
    endtask

    task automatic quiet();
        rst = 1; if_valid = 0; if_pc = 32'd0; if_inst = NOP_INST; ex_stall = 0; flush = 0;
        ex_wreg = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_waddr = 0; mem_wdata = 0;
        rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [6:0]  opcs [10];
        opcs = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR,
                 OPC_JAL, OPC_LUI, OPC_AUIPC, 7'b1111111};
        i = $urandom;
        i[6:0]   = opcs[$urandom_range(0, 9)];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL scoreboard_empty: got no expectation at %0t, required one per edge", $time);
        end else begin
            e = q.pop_front();
            if (e.hold) e = last_e;
            else last_e = e;
            check("id_valid", 32'(id_valid), 32'(e.valid));
            if (e.chk) begin
                check("id_pc", id_pc, e.pc);
                check("id_op", 32'(id_op), 32'(e.op));
                check("id_funct3", 32'(id_funct3), 32'(e.f3));
                check("id_rs1_val", id_rs1_val, e.rs1);
                check("id_rs2_val", id_rs2_val, e.rs2);
                check("id_imm", id_imm, e.imm);
                check("id_rd", 32'(id_rd), 32'(e.rd));
                check("id_wreg", 32'(id_wreg), 32'(e.wreg));
                check("id_is_load", 32'(id_is_load), 32'(e.ld));
                check("id_is_store", 32'(id_is_store), 32'(e.st));
                check("id_is_branch", 32'(id_is_branch), 32'(e.br));
                check("id_illegal", 32'(id_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        // reset held with busy random inputs
        for (int k = 0; k < 2; k++) begin
            quiet();
            rst = 0; if_valid = 1; if_inst = rand_inst(); if_pc = $urandom;
            ex_stall = 1'($urandom); ex_wreg = 1; ex_is_load = 1; ex_waddr = if_inst[19:15];
            cycle();
            check("reset_id_valid", 32'(id_valid), 32'd0);
            check("reset_stall_req", 32'(stall_seen), 32'd0);
        end

        // ADD x3,x1,x2: EX wins over MEM on rs1, rs2 from register file
        quiet();
        if_valid = 1; if_pc = 32'h100; if_inst = 32'h002081B3;
        ex_wreg = 1; ex_waddr = 1; ex_wdata = 32'hAAAA;
        mem_wreg = 1; mem_waddr = 1; mem_wdata = 32'hBBBB;
        rf_rdata1 = 32'h1111; rf_rdata2 = 32'h5555;
        cycle();
        check("first_valid", 32'(id_valid), 32'd1);
        check("fwd_ex_rs1", id_rs1_val, 32'hAAAA);
        check("rf_rs2", id_rs2_val, 32'h5555);
        mem_waddr = 2; mem_wdata = 32'h1234;
        cycle();
        check("fwd_ex_rs1_b", id_rs1_val, 32'hAAAA);
        check("fwd_mem_rs2", id_rs2_val, 32'h1234);

        // ADDI x4,x0,5 with EX writing x0
        quiet();
        if_valid = 1; if_inst = 32'h00500213; ex_wreg = 1; ex_waddr = 0; ex_wdata = 32'hFFFF;
        cycle();
        check("x0_operand", id_rs1_val, 32'd0);

        // load-use on ADDI x6,x5,1
        quiet();
        if_valid = 1; if_pc = 32'h200; if_inst = 32'h00128313;
        ex_is_load = 1; ex_wreg = 1; ex_waddr = 5;
        cycle();
        check("loaduse_stall", 32'(stall_seen), 32'd1);
        check("loaduse_bubble", 32'(id_valid), 32'd0);
        ex_is_load = 0; ex_wreg = 0; mem_wreg = 1; mem_waddr = 5; mem_wdata = 7;
        cycle();
        check("loaduse_valid", 32'(id_valid), 32'd1);
        check("loaduse_rs1", id_rs1_val, 32'd7);
        check("loaduse_imm", id_imm, 32'd1);

        // flush beats ex_stall
        quiet();
        if_valid = 1; if_inst = 32'h002081B3; flush = 1; ex_stall = 1;
        cycle();
        check("flush_stall_req", 32'(stall_seen), 32'd0);
        check("flush_valid", 32'(id_valid), 32'd0);

        quiet();
        if_valid = 1; if_inst = 32'hFE000EE3;
        cycle();
        check("beq_imm", id_imm, 32'hFFFF_FFFC);
        check("beq_branch", 32'(id_is_branch), 32'd1);
        check("beq_wreg", 32'(id_wreg), 32'd0);
        if_inst = 32'h123450B7;
        cycle();
        check("lui_imm", id_imm, 32'h1234_5000);
        if_inst = 32'h000000FF;
        cycle();
        check("illegal_flag", 32'(id_illegal), 32'd1);
        check("illegal_wreg", 32'(id_wreg), 32'd0);

        // random traffic; IF/ID holds its instruction while stall_req is up
        stall_prev = 0;
        for (int n = 0; n < 800; n++) begin
            if (!stall_prev) begin
                if_valid = ($urandom_range(0, 9) < 8);
                if_inst  = rand_inst();
                if_pc    = $urandom & 32'hFFFF_FFFC;
            end
            rst        = ($urandom_range(0, 49) != 0);
            ex_stall   = ($urandom_range(0, 6) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            ex_wreg    = ($urandom_range(0, 9) < 7);
            ex_waddr   = 5'($urandom_range(0, 7));
            ex_wdata   = $urandom;
            ex_is_load = ($urandom_range(0, 2) == 0);
            mem_wreg   = ($urandom_range(0, 9) < 7);
            mem_waddr  = 5'($urandom_range(0, 7));
            mem_wdata  = $urandom;
            rf_rdata1  = $urandom;
            rf_rdata2  = $urandom;
            cycle();
        end

        quiet();
        cycle();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
